// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller: state encoding,
// frame geometry and parity-sense constants.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int DATA_BITS = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_e;

endpackage

// File: rtl/parity_gen.sv
// 8-bit XOR reduction: out is 1 when the byte holds an odd number of ones.
module parity_gen (
  input  logic [7:0] in,
  output logic       out
);

  assign out = ^in;

endmodule

// File: rtl/uart_tx_ctrl.sv
// Transmit-side UART frame controller. A byte accepted over valid/ready is
// sent as start bit, 8 data bits LSB first, optional parity and 1 or 2 stop
// bits. Every output is registered and driven from the next-state values so
// the line changes exactly on bit boundaries.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       par_en,
  input  logic       par_odd,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_e        state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift_reg;
  logic             par_en_q;
  logic             par_bit_q;
  logic             load;
  logic             data_parity;
  logic             tx_n, tx_ready_n, busy_n, done_n;

  parity_gen u_parity (
    .in  (tx_data),
    .out (data_parity)
  );

  // Next-state logic: the baud counter paces each bit, bit_idx walks the data
  // bits and then the stop bits, and the registered outputs follow the state
  // being entered.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    load       = 1'b0;

    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        bit_idx_n  = '0;
        if (tx_valid && tx_ready) begin
          load    = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (baud_cnt == CNT_LAST) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == CNT_LAST) begin
          baud_cnt_n = '0;
          if (bit_idx == DATA_LAST) begin
            bit_idx_n = '0;
            state_n   = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (baud_cnt == CNT_LAST) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = STOP;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt == CNT_LAST) begin
          baud_cnt_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_idx_n = '0;
            state_n   = IDLE;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        baud_cnt_n = '0;
        bit_idx_n  = '0;
        state_n    = IDLE;
      end
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_reg[bit_idx_n];
      PARITY:  tx_n = par_bit_q;
      default: tx_n = 1'b1;
    endcase

    tx_ready_n = (state_n == IDLE);
    busy_n     = (state_n != IDLE);
    done_n     = (state_n == STOP) && (baud_cnt_n == CNT_LAST) && (bit_idx_n == STOP_LAST);
  end

  // State register with counters; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
    end
  end

  // Frame contents are captured once at acceptance so later input changes
  // cannot disturb the byte being sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (load) begin
      shift_reg <= tx_data;
      par_en_q  <= par_en;
      par_bit_q <= data_parity ^ (par_odd == PAR_ODD);
    end
  end

  // Registered outputs; reset forces the idle line and ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx       <= tx_n;
      tx_ready <= tx_ready_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl. Two instances (1 and 2 stop bits)
// share the same stimulus; a frame-level model predicts every output cycle,
// and directed literal checks pin the model's frame shapes.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       par_en;
  logic       par_odd;

  logic tx0, rdy0, busy0, done0;
  logic tx1, rdy1, busy1, done1;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic cap_tx   [2][128];
  logic cap_done [2][128];

  logic [15:0] m_bits [2];
  int          m_len  [2];
  int          m_pos  [2];
  bit          m_act  [2];

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (rdy0),
    .par_en   (par_en),
    .par_odd  (par_odd),
    .tx       (tx0),
    .busy     (busy0),
    .done     (done0)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (rdy1),
    .par_en   (par_en),
    .par_odd  (par_odd),
    .tx       (tx1),
    .busy     (busy1),
    .done     (done1)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole frame as a bit list, bit 0 first on the line; unused upper bits
  // are ones so stop bits need no special handling.
  function automatic logic [15:0] build_frame(input logic [7:0] d, input logic pe, input logic po);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (pe) f[9] = po ? ($countones(d) % 2 == 0) : ($countones(d) % 2 == 1);
    return f;
  endfunction

  function automatic int frame_len(input logic pe, input int s);
    return (1 + 8 + (pe ? 1 : 0) + s) * CPB;
  endfunction

  // Frame-level model: one cycle counter per instance walks the bit list.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d] <= 1'b0;
        m_pos[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!m_act[d] && tx_valid) begin
          m_act[d]  <= 1'b1;
          m_pos[d]  <= 0;
          m_bits[d] <= build_frame(tx_data, par_en, par_odd);
          m_len[d]  <= frame_len(par_en, d + 1);
        end else if (m_act[d]) begin
          if (m_pos[d] + 1 == m_len[d]) m_act[d] <= 1'b0;
          m_pos[d] <= m_pos[d] + 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("dut1_tx",    {31'd0, tx0},   {31'd0, m_act[0] ? m_bits[0][m_pos[0]/CPB] : 1'b1});
      check_output("dut1_ready", {31'd0, rdy0},  {31'd0, !m_act[0]});
      check_output("dut1_busy",  {31'd0, busy0}, {31'd0, m_act[0]});
      check_output("dut1_done",  {31'd0, done0}, {31'd0, m_act[0] && (m_pos[0] == m_len[0] - 1)});
      check_output("dut2_tx",    {31'd0, tx1},   {31'd0, m_act[1] ? m_bits[1][m_pos[1]/CPB] : 1'b1});
      check_output("dut2_ready", {31'd0, rdy1},  {31'd0, !m_act[1]});
      check_output("dut2_busy",  {31'd0, busy1}, {31'd0, m_act[1]});
      check_output("dut2_done",  {31'd0, done1}, {31'd0, m_act[1] && (m_pos[1] == m_len[1] - 1)});
    end
  end

  // Waits until both instances are idle, then offers a byte; returns just
  // after the accepting clock edge.
  task automatic apply_stimulus(input logic [7:0] d, input logic pe, input logic po);
    int k;
    k = 0;
    @(negedge clk);
    while (!(rdy0 && rdy1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check_output("idle_timeout", 32'd0, 32'd1);
    tx_data  = d;
    par_en   = pe;
    par_odd  = po;
    tx_valid = 1'b1;
    @(posedge clk);
  endtask

  // Records both lines for n cycles after acceptance; optionally drops
  // tx_valid and rewrites the inputs mid-frame.
  task automatic capture(input int ncyc, input int drop_at, input int change_at,
                         input logic [7:0] nd, input logic npe, input logic npo);
    for (int n = 0; n < 128; n++) begin
      cap_tx[0][n] = 1'b1; cap_tx[1][n] = 1'b1;
      cap_done[0][n] = 1'b0; cap_done[1][n] = 1'b0;
    end
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      cap_tx[0][n] = tx0;   cap_done[0][n] = done0;
      cap_tx[1][n] = tx1;   cap_done[1][n] = done1;
      if (n == drop_at) tx_valid = 1'b0;
      if (n == change_at) begin
        tx_data = nd;
        par_en  = npe;
        par_odd = npo;
      end
    end
  endtask

  function automatic logic [15:0] observed_bits(input int sel, input int first, input int nbits);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++) r[i] = cap_tx[sel][first + CPB*i + 1];
    return r;
  endfunction

  function automatic int first_done(input int sel);
    for (int n = 1; n < 128; n++) if (cap_done[sel][n]) return n;
    return -1;
  endfunction

  function automatic int done_count(input int sel, input int from, input int upto);
    int c;
    c = 0;
    for (int n = from; n <= upto; n++) if (cap_done[sel][n]) c++;
    return c;
  endfunction

  // Overall time limit.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Directed test sequence.
  initial begin
    rst_n    = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    par_en   = 1'b0;
    par_odd  = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_tx",    {31'd0, tx0},   32'd1);
    check_output("reset_ready", {31'd0, rdy0},  32'd1);
    check_output("reset_busy",  {31'd0, busy0}, 32'd0);
    check_output("reset_done",  {31'd0, done0}, 32'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    $display("[TB] 0xA5 even parity");
    apply_stimulus(8'hA5, 1'b1, 1'b0);
    capture(60, 1, 0, 8'h00, 1'b0, 1'b0);
    check_output("a5_bits",  {16'd0, observed_bits(0, 0, 11)}, 32'b101_0100_1010);
    check_output("a5_done",  first_done(0), 32'd44);
    check_output("a5_ndone", done_count(0, 1, 60), 32'd1);
    check_output("a5_done2", first_done(1), 32'd48);

    $display("[TB] 0x07 odd then even parity");
    apply_stimulus(8'h07, 1'b1, 1'b1);
    capture(50, 1, 0, 8'h00, 1'b0, 1'b0);
    check_output("07_odd_bits", {16'd0, observed_bits(0, 0, 11)}, 32'b100_0000_1110);
    apply_stimulus(8'h07, 1'b1, 1'b0);
    capture(50, 1, 0, 8'h00, 1'b0, 1'b0);
    check_output("07_even_bits", {16'd0, observed_bits(0, 0, 11)}, 32'b110_0000_1110);

    $display("[TB] 0x00 no parity");
    apply_stimulus(8'h00, 1'b0, 1'b0);
    capture(60, 1, 0, 8'h00, 1'b0, 1'b0);
    check_output("00_bits_2stop", {16'd0, observed_bits(1, 0, 11)}, 32'b110_0000_0000);
    check_output("00_done_2stop", first_done(1), 32'd44);
    check_output("00_done_1stop", first_done(0), 32'd40);

    $display("[TB] back-to-back 0x3C then 0xC3");
    apply_stimulus(8'h3C, 1'b0, 1'b0);
    capture(90, 46, 10, 8'hC3, 1'b0, 1'b0);
    check_output("b2b_first_bits",  {16'd0, observed_bits(0, 0, 10)}, 32'b10_0111_1000);
    check_output("b2b_first_done",  first_done(0), 32'd40);
    check_output("b2b_gap_high",    {31'd0, cap_tx[0][41]}, 32'd1);
    check_output("b2b_second_start", {31'd0, cap_tx[0][42]}, 32'd0);
    check_output("b2b_second_bits", {16'd0, observed_bits(0, 41, 10)}, 32'b11_1000_0110);
    check_output("b2b_second_done", done_count(0, 41, 81), 32'd1);
    check_output("b2b_second_dpos", {31'd0, cap_done[0][81]}, 32'd1);

    $display("[TB] reset during data bit 3");
    apply_stimulus(8'h5A, 1'b1, 1'b0);
    capture(18, 1, 0, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_tx",    {31'd0, tx0},   32'd1);
    check_output("midrst_ready", {31'd0, rdy0},  32'd1);
    check_output("midrst_busy",  {31'd0, busy0}, 32'd0);
    check_output("midrst_done",  {31'd0, done0}, 32'd0);
    check_output("midrst_tx2",   {31'd0, tx1},   32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(8'h96, 1'b1, 1'b1);
    capture(60, 1, 0, 8'h00, 1'b0, 1'b0);
    check_output("post_rst_bits", {16'd0, observed_bits(0, 0, 11)}, 32'b111_0010_1100);
    check_output("post_rst_done", first_done(0), 32'd44);

    $display("[TB] config toggled mid-frame");
    apply_stimulus(8'hA5, 1'b1, 1'b0);
    capture(60, 1, 8, 8'h00, 1'b0, 1'b1);
    check_output("latch_bits",  {16'd0, observed_bits(0, 0, 11)}, 32'b101_0100_1010);
    check_output("latch_done",  first_done(0), 32'd44);
    check_output("latch_done2", first_done(1), 32'd48);

    repeat (5) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side UART frame controller. Accepts a byte over a valid/ready handshake, latches it with its parity configuration, and serialises start bit, 8 data bits LSB-first, an optional parity bit and 1 or 2 stop bits onto the line at a baud rate set by an internal clock divider. Parity comes from the existing 8-bit XOR-reduction block (in[7:0] -> out), which this controller instantiates. The block sits between the host-side byte source and the TX pin.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period; legal values are 2 or more.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tx_data  input  8  byte to send
tx_valid  input  1  tx_data and config are valid
tx_ready  output  1  controller can accept a byte
par_en  input  1  1 = append parity bit
par_odd  input  1  1 = odd parity, 0 = even parity
tx  output  1  serial line, idle high
busy  output  1  frame in progress
done  output  1  one-cycle pulse in the last cycle of the final stop bit

Behaviour:
- Reset (async assert, sync release) drives tx=1, tx_ready=1, busy=0, done=0, state=IDLE, and clears the baud counter and bit index.
- Reset mid-frame aborts the frame immediately: tx returns to 1 and no done pulse is issued.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE: tx_ready=1, busy=0, tx=1.
  - On tx_valid && tx_ready (cycle T), latch tx_data into shift_reg, latch par_en, and compute par_bit = parity_gen(tx_data) ^ par_odd.
  - Go to START. tx_ready falls at T+1.
- START: tx=0 from T+1 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift_reg[bit_idx] with bit_idx counting 0..7. Each bit is held for CLKS_PER_BIT cycles. After bit 7, go to PARITY if the latched par_en=1, otherwise to STOP.
- PARITY: tx=par_bit for CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - done=1 in the final cycle of the final stop bit.
  - The next cycle is IDLE with tx_ready=1.
- busy equals !tx_ready.
- Frame length is CLKS_PER_BIT*(10+par_en+STOP_BITS-1) cycles, measured from T+1.
- Back-to-back frames: a byte offered while ready is low is held off and is not lost. It is accepted in the first IDLE cycle, giving a gap of exactly one clk of idle-high between frames.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Cleared on acceptance.
- Changes to tx_data, par_en or par_odd after acceptance have no effect on the frame in flight.
- tx_valid is ignored outside IDLE. No requirement is placed on it while ready is low, and it need not be held.

Decomposition:
- Shared uart_pkg holds:
  - state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
  - DATA_BITS=8
  - PAR_EVEN=0 and PAR_ODD=1
- One sub-module: the existing parity_gen XOR-reduction block, instantiated on tx_data at acceptance.
- Baud counter and FSM stay inline in uart_tx_ctrl.

Test Plan:
1. CLKS_PER_BIT=4, STOP_BITS=1, par_en=1, par_odd=0, send 0xA5 -> tx sequence per 4-clk bit is 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Frame is 44 cycles and done pulses at cycle 44 after T.
2. Same setup with par_odd=1, send 0x07 -> data 1,1,1,0,0,0,0,0, parity 0. Then par_odd=0 on 0x07 -> parity 1.
3. par_en=0, STOP_BITS=2, send 0x00 -> start bit, 8 zeros, stop high for 8 clks. Frame is 44 cycles with no parity slot.
4. Hold tx_valid high with 0x3C then 0xC3 -> second frame's start bit begins exactly 1 idle clk after done. tx_data changed mid-frame does not alter the first frame.
5. Assert rst_n=0 during data bit 3 -> tx=1, tx_ready=1 and busy=0 asynchronously. No done pulse. The next accepted byte transmits correctly.
6. Toggle par_odd and par_en mid-frame -> parity bit and frame length match the values latched at acceptance.
